// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types for the SPI command path: scheduler FSM states, the latched
// command record handed to SPI_driver, and the register byte width.
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic                  is_write;
        logic [SPI_BYTE_W-1:0] addr;
        logic [SPI_BYTE_W-1:0] wdata;
        logic [SPI_BYTE_W-1:0] nregs;
    } spi_cmd_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the requester
// after last_grant and wraps, so the most recently served requester has the
// lowest priority.
//
// Ports:
//   req         in   N_REQ  pending requests
//   last_grant  in   ID_W   index of the previously granted requester
//   gnt         out  N_REQ  one-hot winner (zero when nothing is pending)
//   gnt_id      out  ID_W   index of the winner
//   any         out  1      at least one request pending
// -----------------------------------------------------------------------------
module spi_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    always_comb begin
        logic [31:0]     w_idx;
        logic [ID_W-1:0] w_idx_n;

        gnt     = '0;
        gnt_id  = '0;
        any     = 1'b0;
        w_idx   = '0;
        w_idx_n = '0;
        // Offset 1 is the first candidate; offset N_REQ wraps back to last_grant.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx   = (32'(last_grant) + k) % N_REQ;
            w_idx_n = ID_W'(w_idx);
            if (!any && req[w_idx_n]) begin
                any          = 1'b1;
                gnt[w_idx_n] = 1'b1;
                gnt_id       = w_idx_n;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// spi_cmd_scheduler
// Shares one SPI_driver between N_REQ requesters. Round-robin picks a pending
// request, the command is latched and strobed into the driver, and the
// scheduler waits for a fresh rising edge of the matching completion flag.
// A per-requester response pulse follows; on timeout the driver is held in
// reset for the enforced inter-command gap.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_ready       per-requester handshake (ready is combinational)
//   req_is_write/addr/wdata/nregs  per-requester command fields, 8 bits each
//   rsp_valid, rsp_timeout    one-cycle completion pulse and its abort flag
//   busy, grant_id            status: not idle, current/last granted index
//   drv_*                     command interface to SPI_driver
//   drv_write_complete/drv_read_complete  driver completion levels
//   drv_rstn                  local driver reset, active-low
// -----------------------------------------------------------------------------
module spi_cmd_scheduler
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0]              req_is_write,
    input  logic [N_REQ*SPI_BYTE_W-1:0]   req_addr,
    input  logic [N_REQ*SPI_BYTE_W-1:0]   req_wdata,
    input  logic [N_REQ*SPI_BYTE_W-1:0]   req_nregs,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          drv_new_command,
    output logic                          drv_is_write,
    output logic [SPI_BYTE_W-1:0]         drv_write_register_addr,
    output logic [SPI_BYTE_W-1:0]         drv_write_data,
    output logic [SPI_BYTE_W-1:0]         drv_start_read_register_addr,
    output logic [SPI_BYTE_W-1:0]         drv_num_regs_to_read,
    input  logic                          drv_write_complete,
    input  logic                          drv_read_complete,
    output logic                          drv_rstn
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    // Terminal values are one below the limit: the counter value seen in the
    // last allowed cycle, before that cycle's increment lands.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    spi_cmd_t         r_cmd;
    spi_cmd_t         w_sel_cmd;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_grant_id;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_id;
    logic             w_any;
    logic             w_accept;
    logic             w_zero_len;

    logic             r_wc_q;
    logic             r_rc_q;
    logic             w_flag;
    logic             w_flag_q;
    logic             w_edge;

    logic [CNT_W-1:0] r_to_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_timed_out;

    logic [N_REQ-1:0] r_rsp_valid;
    logic             r_rsp_timeout;
    logic             r_busy;
    logic             r_new_cmd;
    logic             r_drv_rstn;

    // -------------------------------------------------------------------------
    // Arbitration and request selection
    // -------------------------------------------------------------------------
    spi_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .gnt        (w_gnt),
        .gnt_id     (w_gnt_id),
        .any        (w_any)
    );

    // Ready is forced low while reset is asserted so requesters never see an
    // offer from a scheduler that is being cleared.
    assign req_ready = (r_state == IDLE && rstn) ? w_gnt : '0;
    assign w_accept  = (r_state == IDLE) && w_any;

    always_comb begin
        w_sel_cmd = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_sel_cmd.is_write = req_is_write[i];
                w_sel_cmd.addr     = req_addr[i*SPI_BYTE_W +: SPI_BYTE_W];
                w_sel_cmd.wdata    = req_wdata[i*SPI_BYTE_W +: SPI_BYTE_W];
                w_sel_cmd.nregs    = req_nregs[i*SPI_BYTE_W +: SPI_BYTE_W];
            end
        end
    end

    // A read of zero registers needs no bus traffic and is answered directly.
    assign w_zero_len = !w_sel_cmd.is_write && (w_sel_cmd.nregs == '0);

    // -------------------------------------------------------------------------
    // Completion edge detection: only a fresh rising edge of the flag that
    // matches the command type ends WAIT; a level left high by an earlier
    // command is ignored because its registered copy is already high.
    // -------------------------------------------------------------------------
    assign w_flag   = r_cmd.is_write ? drv_write_complete : drv_read_complete;
    assign w_flag_q = r_cmd.is_write ? r_wc_q : r_rc_q;
    assign w_edge   = w_flag && !w_flag_q;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_len ? RESP : ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                // An edge in the final allowed cycle still counts as success.
                if (w_edge || (r_to_cnt == TO_LAST)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: w_state_nxt = GAP;
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Command latch, grant tracking, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd         <= '0;
            r_last_grant  <= ID_W'(N_REQ - 1);
            r_grant_id    <= '0;
            r_wc_q        <= 1'b0;
            r_rc_q        <= 1'b0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_timed_out   <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_new_cmd     <= 1'b0;
            r_drv_rstn    <= 1'b1;
        end else begin
            r_wc_q <= drv_write_complete;
            r_rc_q <= drv_read_complete;

            if (w_accept) begin
                r_cmd        <= w_sel_cmd;
                r_last_grant <= w_gnt_id;
                r_grant_id   <= w_gnt_id;
                r_timed_out  <= 1'b0;
            end else if (r_state == WAIT && w_state_nxt == RESP) begin
                r_timed_out <= !w_edge;
            end

            r_to_cnt  <= (r_state == WAIT) ? r_to_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;

            r_rsp_valid   <= '0;
            r_rsp_timeout <= 1'b0;
            if (w_state_nxt == RESP) begin
                // From IDLE the grant is being registered this very edge.
                r_rsp_valid   <= (r_state == IDLE) ? w_gnt : (N_REQ'(1) << r_grant_id);
                r_rsp_timeout <= (r_state == WAIT) && !w_edge;
            end

            r_busy     <= (w_state_nxt != IDLE);
            r_new_cmd  <= (w_state_nxt == ISSUE);
            r_drv_rstn <= !((w_state_nxt == GAP) && r_timed_out);
        end
    end

    assign rsp_valid                    = r_rsp_valid;
    assign rsp_timeout                  = r_rsp_timeout;
    assign busy                         = r_busy;
    assign grant_id                     = r_grant_id;
    assign drv_new_command              = r_new_cmd;
    assign drv_is_write                 = r_cmd.is_write;
    assign drv_write_register_addr      = r_cmd.addr;
    assign drv_write_data               = r_cmd.wdata;
    assign drv_start_read_register_addr = r_cmd.addr;
    assign drv_num_regs_to_read         = r_cmd.nregs;
    assign drv_rstn                     = r_drv_rstn;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_scheduler
// Self-checking bench for spi_cmd_scheduler with N_REQ=2, TIMEOUT_CYCLES=16,
// GAP_CYCLES=4. Inputs change on the falling edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_spi_cmd_scheduler;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned TO    = 16;
    localparam int unsigned GAP   = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_is_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_nregs;
    logic [1:0]  rsp_valid;
    logic        rsp_timeout;
    logic        busy;
    logic [0:0]  grant_id;
    logic        drv_new_command;
    logic        drv_is_write;
    logic [7:0]  drv_write_register_addr;
    logic [7:0]  drv_write_data;
    logic [7:0]  drv_start_read_register_addr;
    logic [7:0]  drv_num_regs_to_read;
    logic        drv_write_complete;
    logic        drv_read_complete;
    logic        drv_rstn;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_last   = N_REQ - 1;

    spi_cmd_scheduler #(
        .N_REQ          (N_REQ),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .req_valid                    (req_valid),
        .req_ready                    (req_ready),
        .req_is_write                 (req_is_write),
        .req_addr                     (req_addr),
        .req_wdata                    (req_wdata),
        .req_nregs                    (req_nregs),
        .rsp_valid                    (rsp_valid),
        .rsp_timeout                  (rsp_timeout),
        .busy                         (busy),
        .grant_id                     (grant_id),
        .drv_new_command              (drv_new_command),
        .drv_is_write                 (drv_is_write),
        .drv_write_register_addr      (drv_write_register_addr),
        .drv_write_data               (drv_write_data),
        .drv_start_read_register_addr (drv_start_read_register_addr),
        .drv_num_regs_to_read         (drv_num_regs_to_read),
        .drv_write_complete           (drv_write_complete),
        .drv_read_complete            (drv_read_complete),
        .drv_rstn                     (drv_rstn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin reference: first pending requester in the order
    // last+1, last+2, ... taken modulo N_REQ.
    function automatic int rr_winner(input logic [1:0] v, input int last);
        int order [N_REQ];
        for (int k = 0; k < N_REQ; k++) order[k] = (last + 1 + k) % N_REQ;
        foreach (order[k]) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic do_reset();
        req_valid = '0; req_is_write = '0; req_addr = '0; req_wdata = '0; req_nregs = '0;
        drv_write_complete = 1'b0; drv_read_complete = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_last = N_REQ - 1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] nr);
        req_is_write[r]    = wr;
        req_addr[8*r +: 8]  = a;
        req_wdata[8*r +: 8] = d;
        req_nregs[8*r +: 8] = nr;
        req_valid[r]       = 1'b1;
    endtask

    // Call at the falling edge where the request was presented; returns in the
    // acceptance cycle, 1 time unit after the falling edge.
    task automatic wait_accept(output int id, output bit ok);
        ok = 1'b0;
        id = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((req_valid & req_ready) != 2'b00) begin
                ok = 1'b1;
                id = req_ready[1] ? 1 : 0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [9:0] exp_v;
        rstn = 1'b0;
        req_valid = 2'b11; req_is_write = '0; req_addr = '0; req_wdata = '0; req_nregs = '0;
        drv_write_complete = 1'b0; drv_read_complete = 1'b0;
        @(negedge clk); #1;
        exp_v = 10'b00_00_0_0_0_0_0_1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_timeout, busy, drv_new_command, drv_is_write, grant_id,
             drv_rstn} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", {req_ready, rsp_valid, rsp_timeout,
                     busy, drv_new_command, drv_is_write, grant_id, drv_rstn}, exp_v);
        end
        n_checks++;
        if ({drv_write_register_addr, drv_write_data, drv_start_read_register_addr,
             drv_num_regs_to_read} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {drv_write_register_addr,
                     drv_write_data, drv_start_read_register_addr, drv_num_regs_to_read});
        end
        do_reset();
    endtask

    task automatic test_single_write();
        int id; bit ok; int bad;
        set_req(0, 1'b1, 8'h12, 8'hA5, 8'h07);
        wait_accept(id, ok);
        n_checks++;
        if (!ok || id != 0) begin
            n_fail++; $display("FAIL single_accept: got id %0d ok %0d expected id 0", id, ok);
        end
        m_last = 0;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({drv_new_command, drv_is_write, drv_write_register_addr, drv_write_data, busy}
            !== {1'b1, 1'b1, 8'h12, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got new=%0b wr=%0b a=%h d=%h busy=%0b expected 1 1 12 a5 1",
                     drv_new_command, drv_is_write, drv_write_register_addr, drv_write_data, busy);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (drv_new_command !== 1'b0 || rsp_valid !== 2'b00) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL single_pulse: got %0d extra strobes/responses expected 0", bad);
        end
        drv_write_complete = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got %b/%b expected 01/0", rsp_valid, rsp_timeout);
        end
        drv_write_complete = 1'b0;
        bad = 0;
        for (int i = 1; i <= int'(GAP) + 1; i++) begin
            @(negedge clk);
            if (busy !== ((i <= int'(GAP)) ? 1'b1 : 1'b0) || rsp_valid !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL single_gap: got %0d bad gap cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int id; bit ok; int exp_id; int rsp_cyc; logic [7:0] exp_a;
        do_reset();
        set_req(0, 1'b1, 8'h20, 8'h01, 8'h00);
        set_req(1, 1'b1, 8'h31, 8'h02, 8'h00);
        rsp_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(id, ok);
            exp_id = rr_winner(2'b11, m_last);
            n_checks++;
            if (!ok || id != exp_id) begin
                n_fail++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, id, exp_id);
            end
            if (k > 0) begin
                n_checks++;
                if (cyc - rsp_cyc != int'(GAP) + 1) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: got %0d cycles expected %0d", k, cyc - rsp_cyc,
                             GAP + 1);
                end
            end
            m_last = exp_id;
            exp_a = (exp_id == 0) ? 8'h20 : 8'h31;
            @(negedge clk);
            n_checks++;
            if (drv_new_command !== 1'b1 || drv_write_register_addr !== exp_a) begin
                n_fail++;
                $display("FAIL rr_issue%0d: got new=%0b a=%h expected 1 %h", k, drv_new_command,
                         drv_write_register_addr, exp_a);
            end
            @(negedge clk);
            drv_write_complete = 1'b1;
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'(1 << exp_id)) begin
                n_fail++; $display("FAIL rr_rsp%0d: got %b expected %b", k, rsp_valid,
                                   2'(1 << exp_id));
            end
            rsp_cyc = cyc;
            drv_write_complete = 1'b0;
            @(negedge clk);
        end
        req_valid = '0;
        repeat (GAP + 1) @(negedge clk);
    endtask

    task automatic test_stale_read();
        int id; bit ok; int early;
        drv_read_complete = 1'b1;
        repeat (2) @(negedge clk);
        set_req(1, 1'b0, 8'h40, 8'h00, 8'h03);
        wait_accept(id, ok);
        n_checks++;
        if (!ok || id != 1) begin
            n_fail++; $display("FAIL stale_accept: got %0d expected 1", id);
        end
        m_last = 1;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({drv_new_command, drv_is_write, drv_start_read_register_addr, drv_num_regs_to_read}
            !== {1'b1, 1'b0, 8'h40, 8'h03}) begin
            n_fail++;
            $display("FAIL stale_issue: got new=%0b wr=%0b a=%h n=%h expected 1 0 40 03",
                     drv_new_command, drv_is_write, drv_start_read_register_addr,
                     drv_num_regs_to_read);
        end
        early = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) early++;
            if (i == 2) drv_write_complete = 1'b1;
            if (i == 9) drv_read_complete = 1'b0;
        end
        @(negedge clk);
        if (rsp_valid !== 2'b00) early++;
        n_checks++;
        if (early != 0) begin
            n_fail++; $display("FAIL stale_early: got %0d early responses expected 0", early);
        end
        drv_read_complete = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 2'b10 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL stale_rsp: got %b/%b expected 10/0", rsp_valid, rsp_timeout);
        end
        drv_read_complete = 1'b0;
        drv_write_complete = 1'b0;
        repeat (GAP + 1) @(negedge clk);
    endtask

    task automatic test_timeout();
        int id; bit ok; int n; int bad;
        set_req(1, 1'b1, 8'h55, 8'h66, 8'h00);
        wait_accept(id, ok);
        m_last = 1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = '0;
            if (rsp_valid !== 2'b00) begin n = i; break; end
        end
        n_checks++;
        if (n != int'(TO) + 2 || rsp_valid !== 2'b10 || rsp_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rsp: got n=%0d rv=%b to=%b expected n=%0d rv=10 to=1", n,
                     rsp_valid, rsp_timeout, TO + 2);
        end
        bad = 0;
        for (int i = 1; i <= int'(GAP) + 1; i++) begin
            @(negedge clk);
            if (drv_rstn !== ((i <= int'(GAP)) ? 1'b0 : 1'b1)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL timeout_drv_rstn: got %0d wrong cycles expected 0", bad);
        end
        // Next request is served normally; its edge lands in the last WAIT cycle.
        set_req(0, 1'b1, 8'h77, 8'h88, 8'h00);
        wait_accept(id, ok);
        m_last = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = '0;
            if (rsp_valid !== 2'b00) begin n = i; break; end
            if (i == int'(TO) + 1) drv_write_complete = 1'b1;
        end
        n_checks++;
        if (n != int'(TO) + 2 || rsp_valid !== 2'b01 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_edge: got n=%0d rv=%b to=%b expected n=%0d rv=01 to=0", n,
                     rsp_valid, rsp_timeout, TO + 2);
        end
        drv_write_complete = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drv_rstn !== 1'b1) begin
            n_fail++; $display("FAIL limit_drv_rstn: got %b expected 1", drv_rstn);
        end
        repeat (GAP) @(negedge clk);
    endtask

    task automatic test_zero_len();
        int id; bit ok; int n_rsp; int nc; logic [1:0] rv; logic rto;
        set_req(0, 1'b0, 8'h10, 8'h00, 8'h00);
        wait_accept(id, ok);
        m_last = 0;
        n_rsp = 0; nc = 0; rv = '0; rto = 1'b0;
        for (int i = 1; i <= int'(GAP) + 3; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = '0;
            if (drv_new_command !== 1'b0) nc++;
            if (rsp_valid !== 2'b00 && n_rsp == 0) begin
                n_rsp = i; rv = rsp_valid; rto = rsp_timeout;
            end
        end
        n_checks++;
        if (n_rsp != 1 || rv !== 2'b01 || rto !== 1'b0 || nc != 0) begin
            n_fail++;
            $display("FAIL zero_len: got n=%0d rv=%b to=%b strobes=%0d expected 1 01 0 0",
                     n_rsp, rv, rto, nc);
        end
    endtask

    task automatic test_reset_mid();
        int id; bit ok;
        set_req(0, 1'b1, 8'h9A, 8'hBC, 8'h00);
        wait_accept(id, ok);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        set_req(1, 1'b1, 8'h01, 8'h02, 8'h00);
        req_valid = 2'b11;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_timeout, busy, drv_new_command, drv_is_write, grant_id,
             drv_rstn} !== 10'b00_00_0_0_0_0_0_1) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got %b expected 0000000001", {req_ready, rsp_valid,
                     rsp_timeout, busy, drv_new_command, drv_is_write, grant_id, drv_rstn});
        end
        n_checks++;
        if ({drv_write_register_addr, drv_write_data} !== 16'h0) begin
            n_fail++; $display("FAIL midreset_data: got %h%h expected 0000",
                               drv_write_register_addr, drv_write_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_last = N_REQ - 1;
        wait_accept(id, ok);
        n_checks++;
        if (!ok || id != rr_winner(2'b11, m_last) || rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_first: got id=%0d rv=%b expected id=%0d rv=00", id,
                     rsp_valid, rr_winner(2'b11, m_last));
        end
    endtask

    task automatic test_random();
        logic [1:0] v; logic wr [2]; logic [7:0] a [2]; logic [7:0] d [2]; logic [7:0] nr [2];
        int id; bit ok; int exp_id; bit zero; int lat; bit exp_to; int exp_n; int got_n;
        logic [1:0] rv; logic rto; logic [1:0] exp_rv;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            v = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                wr[r] = 1'($urandom); a[r] = 8'($urandom); d[r] = 8'($urandom);
                nr[r] = 8'($urandom_range(0, 3));
                set_req(r, wr[r], a[r], d[r], nr[r]);
            end
            req_valid = v;
            exp_id = rr_winner(v, m_last);
            wait_accept(id, ok);
            n_checks++;
            if (!ok || id != exp_id) begin
                n_fail++; $display("FAIL rnd_grant%0d: got %0d expected %0d", it, id, exp_id);
            end
            m_last = exp_id;
            zero = !wr[exp_id] && nr[exp_id] == 8'h00;
            lat = $urandom_range(0, 19);
            exp_to = !zero && lat >= int'(TO);
            exp_n = zero ? 1 : (exp_to ? int'(TO) + 2 : lat + 3);
            exp_rv = 2'(1 << exp_id);
            got_n = 0; rv = '0; rto = 1'b0;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    req_valid = '0;
                    if (!zero) begin
                        n_checks++;
                        if (drv_new_command !== 1'b1 || drv_is_write !== wr[exp_id] ||
                            (wr[exp_id] && (drv_write_register_addr !== a[exp_id] ||
                                            drv_write_data !== d[exp_id])) ||
                            (!wr[exp_id] && (drv_start_read_register_addr !== a[exp_id] ||
                                             drv_num_regs_to_read !== nr[exp_id]))) begin
                            n_fail++;
                            $display("FAIL rnd_issue%0d: got new=%0b wr=%0b wa=%h wd=%h ra=%h n=%h expected wr=%0b a=%h d=%h n=%h",
                                     it, drv_new_command, drv_is_write, drv_write_register_addr,
                                     drv_write_data, drv_start_read_register_addr,
                                     drv_num_regs_to_read, wr[exp_id], a[exp_id], d[exp_id],
                                     nr[exp_id]);
                        end
                    end
                end
                if (rsp_valid !== 2'b00) begin
                    got_n = n; rv = rsp_valid; rto = rsp_timeout;
                    break;
                end
                if (!zero && !exp_to && n == lat + 2) begin
                    if (wr[exp_id]) drv_write_complete = 1'b1;
                    else drv_read_complete = 1'b1;
                end
                // Opposite-type flag rising mid-command must not end it.
                if (!zero && n == 3) begin
                    if (wr[exp_id]) drv_read_complete = 1'b1;
                    else drv_write_complete = 1'b1;
                end
            end
            n_checks++;
            if (got_n != exp_n || rv !== exp_rv || rto !== exp_to) begin
                n_fail++;
                $display("FAIL rnd_rsp%0d: got n=%0d rv=%b to=%b expected n=%0d rv=%b to=%b",
                         it, got_n, rv, rto, exp_n, exp_rv, exp_to);
            end
            drv_write_complete = 1'b0;
            drv_read_complete = 1'b0;
            repeat (GAP + 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stale_read();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_scheduler.md
# spi_cmd_scheduler

Shares one SPI_driver instance between N_REQ command requesters (for example the AXI register path and an autonomous monitor/poller). It round-robin arbitrates among pending requests, drives the driver's command inputs and pulses `new_command`, then waits for the matching completion flag. It returns a per-requester response, and recovers the driver with a timeout and a local driver reset. It sits in the `clk` domain between the requesters and SPI_driver, ahead of the read-data FIFO.

## Interface
- `N_REQ`, default 2: number of requesters, ≥2.
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT cycles before a command is aborted.
- `GAP_CYCLES`, default 4: idle cycles enforced between commands, ≥1.

- `clk`  in  1  single clock; driver and scheduler domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester command pending.
- `req_ready`  out  N_REQ  one-hot acceptance; transfer occurs when `valid & ready`.
- `req_is_write`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*8  write address or read start address; requester i uses `[8i+7:8i]`.
- `req_wdata`  in  N_REQ*8  write data.
- `req_nregs`  in  N_REQ*8  number of registers to read.
- `rsp_valid`  out  N_REQ  1-cycle completion pulse to the granted requester.
- `rsp_timeout`  out  1  qualifies `rsp_valid`; 1 = command aborted.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `drv_new_command`  out  1  command strobe to the driver.
- `drv_is_write`  out  1  to the driver.
- `drv_write_register_addr`, `drv_write_data`, `drv_start_read_register_addr`, `drv_num_regs_to_read`  out  8 each  to the driver.
- `drv_write_complete`, `drv_read_complete`  in  1 each  driver completion flags, treated as levels.
- `drv_rstn`  out  1  driver reset, active-low; the parent ANDs it into the driver reset.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → GAP → IDLE.
- **IDLE**
  - `req_ready` is the combinational one-hot of the round-robin winner among `req_valid`.
  - Search starts at `(last_grant+1) mod N_REQ`.
  - On transfer, the command is latched into an internal `spi_cmd_t`, `last_grant`/`grant_id` are updated, and the FSM goes to ISSUE.
  - Requesters hold their valid and fields stable until ready. Dropping valid before grant is allowed; that request is simply not served.
- **Zero-length read** (`nregs == 0`, read): no ISSUE/WAIT. The FSM goes straight to RESP with `rsp_timeout = 0`, and `drv_new_command` is never asserted.
- **ISSUE** (1 cycle): `drv_new_command = 1`. The `drv_*` fields take the latched command values and stay stable until the next acceptance.
- **WAIT**
  - The completion flag is selected by type: `drv_write_complete` for writes, `drv_read_complete` for reads.
  - Only a rising edge counts, detected against a registered copy of the flag. A stale high level from a prior command is ignored.
  - The timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) clears on entry and increments every WAIT cycle.
  - If the count reaches `TIMEOUT_CYCLES` with no edge, the command times out.
  - An edge in the same cycle as the limit counts as success.
- **RESP** (1 cycle): `rsp_valid[grant_id] = 1`, and `rsp_timeout` is set if the command timed out.
- **GAP** (`GAP_CYCLES` cycles): nothing is accepted. If the command timed out, `drv_rstn = 0` for the whole GAP, then returns to 1.
- **Reset mid-operation**: the FSM goes to IDLE immediately and all outputs take their reset values. An in-flight command is dropped with no `rsp_valid`.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_timeout`, `busy`, `drv_new_command`, `drv_is_write`, all `drv_*` data/address outputs, `grant_id`: 0.
  - `drv_rstn`: 1.
  - `last_grant`: N_REQ-1, so requester 0 has first priority.
- Normal command:
  - Accept at cycle T (IDLE); ISSUE at T+1; WAIT from T+2.
  - A completion rising edge sampled at cycle C gives `rsp_valid` at C+1.
  - GAP runs C+2 … C+1+GAP_CYCLES; earliest next acceptance is C+2+GAP_CYCLES.
- Timeout: `rsp_valid` with `rsp_timeout` at T+2+TIMEOUT_CYCLES.
- Zero-length read: `rsp_valid` at T+1.
- All outputs are registered except `req_ready`.

## Structure
- Package `spi_ctrl_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, WAIT, RESP, GAP).
  - `spi_cmd_t` packed struct {`is_write`, `addr[7:0]`, `wdata[7:0]`, `nregs[7:0]`}.
  - Localparam `SPI_BYTE_W = 8`.
- Sub-module `spi_rr_arbiter`: purely combinational N_REQ round-robin. Inputs are `req` and `last_grant`; outputs are one-hot `gnt`, `gnt_id`, and `any`.
- Top: FSM, command latch, edge detector, timeout counter, gap counter.

## Test plan
- Single write from requester 0 (addr 0x12, data 0xA5):
  - `drv_new_command` pulses exactly one cycle.
  - Driver fields equal 0x12/0xA5.
  - Completion edge at C → `rsp_valid = 2'b01` at C+1, `rsp_timeout = 0`.
- Both requesters hold valid continuously (N_REQ=2): grants alternate 0,1,0,1 over 4 commands, and each is separated by ≥GAP_CYCLES idle.
- Read with nregs=3, `drv_read_complete` stuck high from the previous command:
  - No response until a fresh rising edge arrives.
  - A write-complete edge during the read is ignored.
- Timeout with TIMEOUT_CYCLES=16 and no completion:
  - `rsp_valid` with `rsp_timeout = 1` at T+18.
  - `drv_rstn` low for GAP_CYCLES, then the next request is served normally.
- Zero-length read: `rsp_valid` at T+1, `drv_new_command` never asserted.
- `rstn` asserted during WAIT: all outputs return to reset values at once, no `rsp_valid`, and after release requester 0 wins first.
